// File: rtl/inert_seq.sv
// inert_seq: owns the SPI master for the iNEMO sensor. Waits out a power-up
// delay, issues the four init writes, then on each data-ready INT reads the
// six gyro bytes and publishes pitch/roll/yaw rates together with a vld pulse.
// Optional macro INERT_ACCEL_RD_EN adds four accel reads and the ax/ay outputs.
module inert_seq #(
  parameter int DLY_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
`ifdef INERT_ACCEL_RD_EN
  output logic [15:0] ax,
  output logic [15:0] ay,
`endif
  output logic        vld
);

`ifdef INERT_ACCEL_RD_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;  // INIT(k), k held in idx_q
  localparam logic [2:0] RD       = 3'd2;  // RD(k),   k held in idx_q
  localparam logic [2:0] VLD      = 3'd3;
  localparam logic [2:0] IDLE     = 3'd4;

  localparam logic [3:0] LAST_INIT = 4'd3;
  localparam logic [3:0] LAST_RD   = 4'(NRD - 1);

  logic [2:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [DLY_W-1:0]     cnt_q, cnt_d;
  logic                 int_ff_q, int_s_q;
  logic                 wrt_q, wrt_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 vld_q, vld_d;
  // byte k of a read sequence comes from register 0xA2+k
  logic [NRD-1:0][7:0]  hold_q, hold_d;
  logic [NRD-1:0][7:0]  rate_q;

  // Only the low byte of each SPI response carries register data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  function automatic logic [15:0] init_cmd(input logic [3:0] k);
    case (k[1:0])
      2'd0:    return 16'h0D02;  // INT1 on data ready
      2'd1:    return 16'h1053;  // accel 208Hz
      2'd2:    return 16'h1150;  // gyro 208Hz
      default: return 16'h1460;  // rounding
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [3:0] k);
    return {8'hA2 + {4'h0, k}, 8'h00};
  endfunction

  // Two-flop synchroniser for the asynchronous data-ready line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff_q <= 1'b0;
      int_s_q  <= 1'b0;
    end else begin
      int_ff_q <= INT;
      int_s_q  <= int_ff_q;
    end
  end

  // Next-state logic; wrt/cmd for a state are produced on the transition into it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      PWR_WAIT: begin
        if (&cnt_q) begin
          state_d = INIT;
          idx_d   = 4'd0;
          wrt_d   = 1'b1;
          cmd_d   = init_cmd(4'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT: begin
        if (done) begin
          if (idx_q == LAST_INIT) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
            wrt_d = 1'b1;
            cmd_d = init_cmd(idx_q + 4'd1);
          end
        end
      end
      IDLE: begin
        // level-sensitive: INT still high on re-entry starts another read
        if (int_s_q) begin
          state_d = RD;
          idx_d   = 4'd0;
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(4'd0);
        end
      end
      RD: begin
        if (done) begin
          for (int k = 0; k < NRD; k++)
            if (idx_q == 4'(k)) hold_d[k] = rd_data[7:0];
          if (idx_q == LAST_RD) begin
            state_d = VLD;
            vld_d   = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            wrt_d = 1'b1;
            cmd_d = rd_cmd(idx_q + 4'd1);
          end
        end
      end
      VLD:     state_d = IDLE;
      default: state_d = PWR_WAIT;
    endcase
  end

  // State, command and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      vld_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

  // Rates load as one word on entry to VLD, so no partial value is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rate_q <= '0;
    else if (vld_d) rate_q <= hold_d;
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = {rate_q[1], rate_q[0]};
  assign roll_rt = {rate_q[3], rate_q[2]};
  assign yaw_rt  = {rate_q[5], rate_q[4]};
`ifdef INERT_ACCEL_RD_EN
  assign ax      = {rate_q[7], rate_q[6]};
  assign ay      = {rate_q[9], rate_q[8]};
`endif

endmodule

// File: tb/tb_inert_seq.sv
// Randomised bench for inert_seq: the bench plays the SPI master's role
// (answers each wrt with a delayed done and a random byte) and predicts
// commands and assembled rates from the sensor register map.
module tb_inert_seq;
`ifdef INERT_ACCEL_RD_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, INT = 1'b0, done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld;
  logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt;
`ifdef INERT_ACCEL_RD_EN
  logic [15:0] ax, ay;
  logic [15:0] exp_ax = 16'h0, exp_ay = 16'h0;
`endif

  int n_chk = 0, n_err = 0, wrt_cnt = 0, vld_cnt = 0;
  bit jitter = 1'b0;
  logic [15:0] exp_p = 16'h0, exp_r = 16'h0, exp_y = 16'h0;
  logic [7:0]  bq [NRD];

  inert_seq #(.DLY_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
`ifdef INERT_ACCEL_RD_EN
    .ax(ax), .ay(ay),
`endif
    .vld(vld));

  always #5 clk = ~clk;

  // pulse counters for delta checks over quiet windows
  always @(posedge clk) begin
    if (wrt) wrt_cnt++;
    if (vld) vld_cnt++;
  end

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] init_cmd(input int k);
    case (k)
      0:       return 16'h0D02;
      1:       return 16'h1053;
      2:       return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input int k);
    return {8'hA2 + 8'(k), 8'h00};
  endfunction

  task automatic chk_rates(input string tag);
    chk(tag, {ptch_rt, roll_rt, yaw_rt}, {exp_p, exp_r, exp_y});
`ifdef INERT_ACCEL_RD_EN
    chk({tag, "_acc"}, {16'h0, ax, ay}, {16'h0, exp_ax, exp_ay});
`endif
  endtask

  // Wait (bounded) for wrt, check command, hold off done for dly cycles, then answer.
  task automatic serve(input logic [15:0] exp_cmd, input logic [7:0] b, input int dly);
    int n = 0;
    while (!wrt && n < 64) begin @(negedge clk); n++; end
    chk("wrt_seen", {47'h0, wrt}, 48'h1);
    chk("cmd", {32'h0, cmd}, {32'h0, exp_cmd});
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (jitter) INT = 1'($urandom_range(0, 1));
      chk("wrt_single", {47'h0, wrt}, 48'h0);
      chk("cmd_hold", {32'h0, cmd}, {32'h0, exp_cmd});
      chk_rates("rates_hold");
    end
    done = 1'b1;
    rd_data = {8'($urandom), b};
    @(negedge clk);
    done = 1'b0;
  endtask

  // Full read sequence using bq[]; INT is set to int_after before the last done.
  task automatic rd_seq(input bit int_after);
    for (int k = 0; k < NRD; k++) begin
      if (k == NRD - 1) begin jitter = 1'b0; INT = int_after; end
      serve(rd_cmd(k), bq[k], $urandom_range(1, 3));
    end
    exp_p = {bq[1], bq[0]};
    exp_r = {bq[3], bq[2]};
    exp_y = {bq[5], bq[4]};
`ifdef INERT_ACCEL_RD_EN
    exp_ax = {bq[7], bq[6]};
    exp_ay = {bq[9], bq[8]};
`endif
    chk("vld_pulse", {47'h0, vld}, 48'h1);
    chk_rates("rates_at_vld");
    @(negedge clk);
    chk("vld_once", {47'h0, vld}, 48'h0);
    chk("gap_no_wrt", {47'h0, wrt}, 48'h0);
    @(negedge clk);
    if (int_after) begin
      chk("b2b_wrt", {47'h0, wrt}, 48'h1);
      chk("b2b_cmd", {32'h0, cmd}, 48'hA200);
    end else begin
      repeat (6) begin
        chk("idle_quiet", {47'h0, wrt}, 48'h0);
        @(negedge clk);
      end
    end
  endtask

  task automatic pwr_init();
    int cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (wrt) break;
    end
    chk("pwr_dly", 48'(cyc), 48'd16);
    for (int k = 0; k < 4; k++) serve(init_cmd(k), 8'h00, $urandom_range(1, 3));
  endtask

  task automatic rand_bytes();
    for (int k = 0; k < NRD; k++) bq[k] = 8'($urandom);
  endtask

  initial begin
    int w0, v0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_wrt", {47'h0, wrt}, 48'h0);
    chk("rst_cmd", {32'h0, cmd}, 48'h0);
    chk("rst_vld", {47'h0, vld}, 48'h0);
    chk_rates("rst_rates");
    rst_n = 1'b1;
    pwr_init();
    chk("no_vld_init", 48'(vld_cnt), 48'd0);

    // spurious done in IDLE
    w0 = wrt_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (6) begin
      chk("spur_no_vld", {47'h0, vld}, 48'h0);
      @(negedge clk);
    end
    chk("spur_no_wrt", 48'(wrt_cnt - w0), 48'd0);

    // directed byte pattern
    bq[0] = 8'h34; bq[1] = 8'h12; bq[2] = 8'hCD;
    bq[3] = 8'hAB; bq[4] = 8'h77; bq[5] = 8'h77;
    for (int k = 6; k < NRD; k++) bq[k] = 8'($urandom);
    INT = 1'b1;
    rd_seq(1'b0);
    chk("dir_ptch", {32'h0, ptch_rt}, 48'h1234);
    chk("dir_roll", {32'h0, roll_rt}, 48'hABCD);
    chk("dir_yaw", {32'h0, yaw_rt}, 48'h7777);

    // back-to-back sequences with INT held high
    w0 = wrt_cnt; v0 = vld_cnt;
    INT = 1'b1;
    for (int s = 0; s < 8; s++) begin
      rand_bytes();
      rd_seq(s != 7);
    end
    chk("b2b_wrt_cnt", 48'(wrt_cnt - w0), 48'(8 * NRD));
    chk("b2b_vld_cnt", 48'(vld_cnt - v0), 48'd8);

    // INT toggling mid-sequence must not add reads
    w0 = wrt_cnt; v0 = vld_cnt;
    INT = 1'b1;
    jitter = 1'b1;
    rand_bytes();
    rd_seq(1'b0);
    chk("jit_wrt_cnt", 48'(wrt_cnt - w0), 48'(NRD));
    chk("jit_vld_cnt", 48'(vld_cnt - v0), 48'd1);

    // withheld done in RD2, then reset while RD3 is issuing
    rand_bytes();
    INT = 1'b1;
    serve(rd_cmd(0), bq[0], 1);
    INT = 1'b0;
    serve(rd_cmd(1), bq[1], 2);
    serve(rd_cmd(2), bq[2], 20);
    begin
      int n = 0;
      while (!wrt && n < 64) begin @(negedge clk); n++; end
    end
    chk("rd3_wrt", {47'h0, wrt}, 48'h1);
    chk("rd3_cmd", {32'h0, cmd}, 48'hA500);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wrt", {47'h0, wrt}, 48'h0);
    chk("arst_cmd", {32'h0, cmd}, 48'h0);
    exp_p = 16'h0; exp_r = 16'h0; exp_y = 16'h0;
`ifdef INERT_ACCEL_RD_EN
    exp_ax = 16'h0; exp_ay = 16'h0;
`endif
    chk_rates("arst_rates");
    @(negedge clk);
    rst_n = 1'b1;
    pwr_init();

    // one more random sequence after re-init
    rand_bytes();
    INT = 1'b1;
    rd_seq(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
